decrypt_round_engine: RTL
=========================

# decrypt_round_engine

Parametrised iterative AES inverse-round engine that generalises the fixed two-round middle decrypt stage. It accepts one 128-bit block through a valid/ready handshake and applies `NUM_ROUNDS` instances of the `inverse_main_mid` round function, one per clock, using per-round keys latched at acceptance. It holds the result until a programmable UART-paced interval has elapsed, then presents it on a valid/ready output. It sits between the UART receive assembler and the UART transmit serialiser in the decryption path.

## Interface
- `NUM_ROUNDS`, 2: inverse rounds applied per block; legal range 1..14.
- `CLK_PER_BIT`, 10417: clock cycles per UART bit.
- `HOLD_BITS`, 159: minimum bit-times from acceptance to output. `PACE_CYCLES = CLK_PER_BIT*HOLD_BITS`; 0 disables pacing.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_data`/`round_keys` valid this cycle.
- `in_data` in 128: ciphertext-side block.
- `round_keys` in 128*NUM_ROUNDS: round i key is `round_keys[128*i +: 128]`; it is applied i-th.
- `in_ready` out 1: engine can accept a block this cycle (combinational).
- `out_valid` out 1: `out_data` holds a finished block.
- `out_data` out 128: result of the last completed block.
- `out_ready` in 1: downstream consumes `out_data` this cycle.
- `busy` out 1: high in ROUND, PACE or OUT.
- `overrun` out 1: sticky; set when `in_valid` is high while `in_ready` is low.

## Operation
- States are IDLE, ROUND, PACE and OUT.
- **IDLE:** `in_ready=1`. On `in_valid`, the engine:
  - latches `in_data` into the working register and all `round_keys` into a key store;
  - clears `round_idx` and `pace_cnt` to 0;
  - goes to ROUND.
- **ROUND:** each cycle, working register <= inverse_main_mid(working, key[round_idx]) and `round_idx` increments. After the `NUM_ROUNDS`-th update the engine goes to PACE.
- **PACE:** waits until `pace_cnt >= PACE_CYCLES-1`, then goes to OUT. With `PACE_CYCLES <= NUM_ROUNDS+1` it passes through PACE in one cycle.
- On entry to OUT, `out_data` <= working register and `out_valid`=1.
- `pace_cnt` is 32 bits. It counts every cycle from acceptance, saturates, and never wraps.
- **OUT:** `out_valid` and `out_data` stay stable until `out_valid && out_ready`.
  - Handshake with `in_valid=0`: clear `out_valid`, go to IDLE.
  - Handshake with `in_valid=1`: `in_ready` is high combinationally (`in_ready = IDLE || (OUT && out_ready)`). The new block is accepted on the same edge and the engine goes straight to ROUND.
- `out_data` retains its value after the handshake until overwritten by the next entry to OUT.
- **Overrun:** `in_valid && !in_ready` sets `overrun`. The offered block is dropped and the in-flight block is unaffected. Only `rst` clears `overrun`.
- Inputs are latched at acceptance, so `round_keys` changes after acceptance do not affect the in-flight block.

## Timing
- Reset values: state IDLE; `out_valid=0`, `out_data=0`, `busy=0`, `overrun=0`, `in_ready=1`.
  - `in_ready` is 1 both during and after reset.
  - Counters and the working register reset to 0.
- Reset mid-operation discards the in-flight block: no `out_valid` is produced, and `out_data` is cleared.
- Acceptance at edge E0 gives `out_valid` high from edge E0+L, with L = max(NUM_ROUNDS+2, PACE_CYCLES+1).
- Throughput: one block per L cycles plus output stall cycles. Back-to-back is possible with zero bubble when `out_ready` is held high.
- `busy` rises at E0 and falls at the handshake edge when returning to IDLE.

## Test plan
- **Reset and idle:** `rst` pulse, no stimulus → all outputs at reset values, `in_ready=1`, no `out_valid` for 1000 cycles.
- **Latency and result:**
  - Params: NUM_ROUNDS=2, CLK_PER_BIT=4, HOLD_BITS=5. Stimulus: one block, `out_ready=1`.
  - Required: `out_valid` at E0+21 for exactly 1 cycle. `out_data` equals the two-round golden model (key0 then key1) for the vectors `data=128'h00112233_44556677_8899aabb_ccddeeff`, `key0=128'h0`, `key1=128'hffff..ff`.
- **No pacing, max rounds:** NUM_ROUNDS=14, HOLD_BITS=0 → `out_valid` at E0+16; data matches the 14-round model.
- **Backpressure and overrun:**
  - Hold `out_ready=0` for 50 cycles after `out_valid`: `out_data` stays stable and `out_valid` stays high.
  - Pulse `in_valid` mid-hold: `overrun` becomes 1 and stays 1 after the handshake; the original result is unchanged.
- **Back-to-back:** hold `out_ready=1` and offer block B in the handshake cycle of block A → B is accepted at the same edge, and `out_valid` for B is asserted exactly L cycles later.
- **Reset mid-operation and key stability:**
  - Toggle `round_keys` in ROUND: the result still matches the latched keys.
  - Assert `rst` in PACE: `out_valid` never rises, `out_data=0`, and a block offered after reset completes normally.

Source files
------------

// File: rtl/decrypt_round_engine.sv
// Iterative AES inverse-round engine: accepts one block, applies NUM_ROUNDS
// inverse middle rounds (one per clock) with keys latched at acceptance, then
// holds the result for a UART-paced interval before presenting it downstream.
module decrypt_round_engine #(
  parameter int unsigned NUM_ROUNDS  = 2,
  parameter int unsigned CLK_PER_BIT = 10417,
  parameter int unsigned HOLD_BITS   = 159
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [127:0]              in_data,
  input  logic [128*NUM_ROUNDS-1:0] round_keys,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [127:0]              out_data,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned IDX_W       = 4;
  localparam logic [63:0] PACE_CYCLES = 64'(CLK_PER_BIT) * 64'(HOLD_BITS);

  typedef enum logic [1:0] {IDLE, ROUND, PACE, OUT} state_t;

  state_t             state, state_nxt;
  logic [127:0]       work;
  logic [127:0]       keys [NUM_ROUNDS];
  logic [127:0]       key_sel;
  logic [IDX_W-1:0]   round_idx;
  logic [31:0]        pace_cnt;
  logic               accept;
  logic               rounds_done;
  logic               pace_done;

  // GF(2^8) multiply by x modulo the AES polynomial
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) shift-and-add multiply
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] acc;
    p   = a;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Inverse S-box: inverse affine map followed by field inversion (x^254)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] p;
    logic [7:0] r;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  // One inverse middle round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
  function automatic logic [127:0] inv_round(input logic [127:0] blk, input logic [127:0] key);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    int           d;
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        d    = 4*((c + r) % 4) + r;
        t[d] = inv_sbox(s[4*c+r]) ^ key[127-8*d -: 8];
      end
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-8*(4*c)   -: 8] = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
      o[127-8*(4*c+1) -: 8] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
      o[127-8*(4*c+2) -: 8] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
      o[127-8*(4*c+3) -: 8] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
    end
    return o;
  endfunction

  // Handshake qualifiers, round-key select and pacing comparison
  always_comb begin
    in_ready    = (state == IDLE) || ((state == OUT) && out_ready);
    accept      = in_valid && in_ready;
    rounds_done = (round_idx == IDX_W'(NUM_ROUNDS));
    pace_done   = (PACE_CYCLES <= 64'd1) || (64'(pace_cnt) >= (PACE_CYCLES - 64'd1));
    key_sel     = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) begin
      if (round_idx == IDX_W'(i)) key_sel = keys[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ROUND;
      ROUND:   if (rounds_done) state_nxt = PACE;
      PACE:    if (pace_done) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = accept ? ROUND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work      <= '0;
      round_idx <= '0;
      pace_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_ROUNDS; i++) keys[i] <= '0;
    end else begin
      out_valid <= (state_nxt == OUT);
      busy      <= (state_nxt != IDLE);
      if (in_valid && !in_ready) overrun <= 1'b1;
      if (accept) begin
        work      <= in_data;
        round_idx <= '0;
        pace_cnt  <= '0;
        for (int i = 0; i < NUM_ROUNDS; i++) keys[i] <= round_keys[128*i +: 128];
      end else begin
        if ((state == ROUND) && !rounds_done) begin
          work      <= inv_round(work, key_sel);
          round_idx <= round_idx + IDX_W'(1);
        end
        // Count from the second cycle after acceptance so that OUT lands at PACE_CYCLES+1
        if ((state != IDLE) && !((state == ROUND) && (round_idx == '0)) && (pace_cnt != '1))
          pace_cnt <= pace_cnt + 32'd1;
      end
      if ((state == PACE) && pace_done) out_data <= work;
    end
  end

endmodule
